// File: rtl/ompss_acc_cmd_endpoint_if.sv
// Command/finish streams and kernel task handshake of one accelerator command endpoint.
// slave = endpoint side, master = manager interconnect plus kernel side.
interface ompss_acc_cmd_endpoint_if #(
  parameter int MAX_ACCS = 16,
  parameter int MAX_ARGS = 15
);
  localparam int AW = $clog2(MAX_ARGS + 1);
  localparam int TW = $clog2(MAX_ACCS);

  logic          cmdin_in_tvalid;
  logic          cmdin_in_tready;
  logic [63:0]   cmdin_in_tdata;
  logic          cmdin_in_tlast;

  logic          cmdout_out_tvalid;
  logic          cmdout_out_tready;
  logic [TW-1:0] cmdout_out_tid;
  logic [63:0]   cmdout_out_tdata;

  logic          task_start_valid;
  logic          task_start_ready;
  logic [63:0]   task_id;
  logic [63:0]   task_parent_id;
  logic [AW-1:0] task_nargs;
  logic [AW-1:0] arg_rd_idx;
  logic [63:0]   arg_rd_data;
  logic          task_done;
  logic          err;

  modport slave (
    input  cmdin_in_tvalid, cmdin_in_tdata, cmdin_in_tlast,
    input  cmdout_out_tready,
    input  task_start_ready, arg_rd_idx, task_done,
    output cmdin_in_tready,
    output cmdout_out_tvalid, cmdout_out_tid, cmdout_out_tdata,
    output task_start_valid, task_id, task_parent_id, task_nargs, arg_rd_data, err
  );

  modport master (
    output cmdin_in_tvalid, cmdin_in_tdata, cmdin_in_tlast,
    output cmdout_out_tready,
    output task_start_ready, arg_rd_idx, task_done,
    input  cmdin_in_tready,
    input  cmdout_out_tvalid, cmdout_out_tid, cmdout_out_tdata,
    input  task_start_valid, task_id, task_parent_id, task_nargs, arg_rd_data, err
  );
endinterface

// File: rtl/ompss_acc_cmd_endpoint.sv
// Parses EXEC_TASK packets into a task register file, starts the kernel, returns a 2-word finish.
// Start 1 cycle after the last word, finish word 0 1 cycle after task_done; cmdin stalls outside receive states.
module ompss_acc_cmd_endpoint #(
  parameter int MAX_ACCS = 16,
  parameter int ACC_ID   = 0,
  parameter int MAX_ARGS = 15
) (
  input logic                      clk,
  input logic                      rstn,
  ompss_acc_cmd_endpoint_if.slave  bus
);
  localparam int AW = $clog2(MAX_ARGS + 1);
  localparam int TW = $clog2(MAX_ACCS);
  localparam logic [7:0] OP_EXEC_TASK = 8'h01;
  localparam logic [7:0] OP_FINISH    = 8'h03;

  typedef enum logic [3:0] {
    S_HDR,
    S_TID,
    S_PID,
    S_ARG,
    S_DRAIN,
    S_EXEC,
    S_RUN,
    S_FIN0,
    S_FIN1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] nargs;
  logic [AW-1:0] cnt;
  logic [63:0]   tid;
  logic [63:0]   pid;
  logic [63:0]   args [MAX_ARGS];
  logic          err_q;

  logic          in_vld;
  logic          in_last;
  logic          hdr_bad;
  logic          is_final;
  logic          in_rdy;
  logic          start_vld;
  logic          out_vld;
  logic [63:0]   out_dat;
  logic          nargs_ld;
  logic          tid_ld;
  logic          pid_ld;
  logic          arg_we;
  logic          err_set;

  assign in_vld   = bus.cmdin_in_tvalid;
  assign in_last  = bus.cmdin_in_tlast;
  assign hdr_bad  = (bus.cmdin_in_tdata[7:0] != OP_EXEC_TASK) ||
                    (int'(bus.cmdin_in_tdata[15:8]) > MAX_ARGS);
  assign is_final = (cnt == nargs - AW'(1));

  // Receive states always take a word, so tvalid alone marks a handshake there.
  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    start_vld = 1'b0;
    out_vld   = 1'b0;
    out_dat   = '0;
    nargs_ld  = 1'b0;
    tid_ld    = 1'b0;
    pid_ld    = 1'b0;
    arg_we    = 1'b0;
    err_set   = 1'b0;
    case (state)
      S_HDR: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          if (hdr_bad || in_last) begin
            err_set   = 1'b1;
            state_nxt = in_last ? S_HDR : S_DRAIN;
          end else begin
            nargs_ld  = 1'b1;
            state_nxt = S_TID;
          end
        end
      end
      S_TID: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          tid_ld = 1'b1;
          if (in_last) begin
            err_set   = 1'b1;
            state_nxt = S_HDR;
          end else begin
            state_nxt = S_PID;
          end
        end
      end
      S_PID: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          pid_ld = 1'b1;
          if (nargs == '0) begin
            if (in_last) begin
              state_nxt = S_EXEC;
            end else begin
              err_set   = 1'b1;
              state_nxt = S_DRAIN;
            end
          end else if (in_last) begin
            err_set   = 1'b1;
            state_nxt = S_HDR;
          end else begin
            state_nxt = S_ARG;
          end
        end
      end
      S_ARG: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          arg_we = 1'b1;
          if (is_final) begin
            if (in_last) begin
              state_nxt = S_EXEC;
            end else begin
              err_set   = 1'b1;
              state_nxt = S_DRAIN;
            end
          end else if (in_last) begin
            err_set   = 1'b1;
            state_nxt = S_HDR;
          end
        end
      end
      S_DRAIN: begin
        in_rdy = 1'b1;
        if (in_vld && in_last) begin
          state_nxt = S_HDR;
        end
      end
      S_EXEC: begin
        start_vld = 1'b1;
        if (bus.task_start_ready) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.task_done) begin
          state_nxt = S_FIN0;
        end
      end
      S_FIN0: begin
        out_vld = 1'b1;
        out_dat = {48'h0, 8'(ACC_ID), OP_FINISH};
        if (bus.cmdout_out_tready) begin
          state_nxt = S_FIN1;
        end
      end
      S_FIN1: begin
        out_vld = 1'b1;
        out_dat = tid;
        if (bus.cmdout_out_tready) begin
          state_nxt = S_HDR;
        end
      end
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_HDR;
      nargs <= '0;
      cnt   <= '0;
      tid   <= '0;
      pid   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (nargs_ld) begin
        nargs <= bus.cmdin_in_tdata[8 +: AW];
      end
      if (tid_ld) begin
        tid <= bus.cmdin_in_tdata;
      end
      if (pid_ld) begin
        pid <= bus.cmdin_in_tdata;
        cnt <= '0;
      end
      if (arg_we) begin
        cnt <= cnt + AW'(1);
      end
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Argument storage needs no reset: reads beyond task_nargs are undefined.
  always_ff @(posedge clk) begin
    if (arg_we) begin
      args[cnt] <= bus.cmdin_in_tdata;
    end
  end

  // rstn gating keeps the stream stalled while reset is asserted.
  assign bus.cmdin_in_tready   = in_rdy & rstn;
  assign bus.cmdout_out_tvalid = out_vld;
  assign bus.cmdout_out_tdata  = out_dat;
  assign bus.cmdout_out_tid    = TW'(ACC_ID);
  assign bus.task_start_valid  = start_vld;
  assign bus.task_id           = tid;
  assign bus.task_parent_id    = pid;
  assign bus.task_nargs        = nargs;
  assign bus.err               = err_q;
  assign bus.arg_rd_data       = (int'(bus.arg_rd_idx) < MAX_ARGS) ? args[bus.arg_rd_idx] : '0;

endmodule

// File: tb/tb_ompss_acc_cmd_endpoint.sv
// Directed plus randomized packet bench for ompss_acc_cmd_endpoint with a packet-level reference model.
module tb_ompss_acc_cmd_endpoint;
  localparam int MAX_ACCS = 16;
  localparam int ACC_ID   = 0;
  localparam int MAX_ARGS = 15;
  localparam int AW       = $clog2(MAX_ARGS + 1);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ompss_acc_cmd_endpoint_if #(.MAX_ACCS(MAX_ACCS), .MAX_ARGS(MAX_ARGS)) bus ();

  ompss_acc_cmd_endpoint #(
    .MAX_ACCS(MAX_ACCS),
    .ACC_ID  (ACC_ID),
    .MAX_ARGS(MAX_ARGS)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] pkt[$];
  logic        err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A packet is a task iff it is EXEC_TASK, nargs fits, and it is exactly 3+nargs words long.
  function automatic bit pkt_ok();
    logic [63:0] h;
    int          n;
    if (pkt.size() < 3) return 1'b0;
    h = pkt[0];
    n = int'(h[15:8]);
    return (h[7:0] == 8'h01) && (n <= MAX_ARGS) && (pkt.size() == 3 + n);
  endfunction

  task automatic mk_valid(input int n, input logic [63:0] t, input logic [63:0] p);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[15:0] = {8'(n), 8'h01};
    pkt.delete();
    pkt.push_back(h);
    pkt.push_back(t);
    pkt.push_back(p);
    for (int j = 0; j < n; j++) pkt.push_back({$urandom, $urandom});
  endtask

  task automatic send_pkt(input bit no_last, output int stalls);
    int budget;
    stalls = 0;
    for (int i = 0; i < pkt.size(); i++) begin
      budget = 0;
      bus.cmdin_in_tvalid = 1'b1;
      bus.cmdin_in_tdata  = pkt[i];
      bus.cmdin_in_tlast  = !no_last && (i == pkt.size() - 1);
      #1;
      while (!bus.cmdin_in_tready && budget < 50) begin
        @(negedge clk);
        #1;
        budget++;
        stalls++;
      end
      if (budget >= 50) begin
        chk("cmdin_tready_timeout", 64'(bus.cmdin_in_tready), 64'd1);
        break;
      end
      @(negedge clk);
    end
    bus.cmdin_in_tvalid = 1'b0;
    bus.cmdin_in_tlast  = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_cmdin_tready", 64'(bus.cmdin_in_tready), 64'd0);
    chk("rst_cmdout_tvalid", 64'(bus.cmdout_out_tvalid), 64'd0);
    chk("rst_start_valid", 64'(bus.task_start_valid), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_task_id", bus.task_id, 64'd0);
    chk("rst_parent_id", bus.task_parent_id, 64'd0);
    chk("rst_nargs", 64'(bus.task_nargs), 64'd0);
    chk("rst_cmdout_tdata", bus.cmdout_out_tdata, 64'd0);
  endtask

  task automatic run_pkt(input int fin_stall, input bit offer);
    bit          ok;
    int          stalls;
    int          n;
    logic [63:0] h;
    logic [63:0] tid_e;
    logic [63:0] pid_e;
    logic [63:0] w0;
    ok = pkt_ok();
    h  = pkt[0];
    send_pkt(1'b0, stalls);
    chk("rx_bubbles", 64'(stalls), 64'd0);
    if (!ok) begin
      err_exp = 1'b1;
      chk("err_after_bad", 64'(bus.err), 64'(err_exp));
      for (int k = 0; k < 3; k++) begin
        chk("bad_no_start", 64'(bus.task_start_valid), 64'd0);
        chk("bad_no_finish", 64'(bus.cmdout_out_tvalid), 64'd0);
        @(negedge clk);
      end
      return;
    end
    n     = int'(h[15:8]);
    tid_e = pkt[1];
    pid_e = pkt[2];
    w0    = {48'h0, 8'(ACC_ID), 8'h03};
    chk("start_latency", 64'(bus.task_start_valid), 64'd1);
    chk("task_id", bus.task_id, tid_e);
    chk("task_parent_id", bus.task_parent_id, pid_e);
    chk("task_nargs", 64'(bus.task_nargs), 64'(n));
    chk("err_level", 64'(bus.err), 64'(err_exp));
    chk("exec_cmdin_stall", 64'(bus.cmdin_in_tready), 64'd0);
    for (int j = 0; j < n; j++) begin
      bus.arg_rd_idx = AW'(j);
      #1;
      chk("arg_rd_data", bus.arg_rd_data, pkt[3 + j]);
    end
    @(negedge clk);
    chk("start_hold", 64'(bus.task_start_valid), 64'd1);
    bus.task_start_ready = 1'b1;
    @(negedge clk);
    bus.task_start_ready = 1'b0;
    chk("run_start_low", 64'(bus.task_start_valid), 64'd0);
    chk("run_no_finish", 64'(bus.cmdout_out_tvalid), 64'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.task_done = 1'b1;
    @(negedge clk);
    bus.task_done = 1'b0;
    chk("fin0_tvalid", 64'(bus.cmdout_out_tvalid), 64'd1);
    chk("fin0_tdata", bus.cmdout_out_tdata, w0);
    chk("fin_tid", 64'(bus.cmdout_out_tid), 64'(ACC_ID));
    if (offer) begin
      bus.cmdin_in_tvalid = 1'b1;
      bus.cmdin_in_tdata  = 64'h0001;
      bus.cmdin_in_tlast  = 1'b0;
    end
    for (int k = 0; k < fin_stall; k++) begin
      @(negedge clk);
      chk("fin0_hold_tvalid", 64'(bus.cmdout_out_tvalid), 64'd1);
      chk("fin0_hold_tdata", bus.cmdout_out_tdata, w0);
      if (offer) chk("fin_cmdin_stall", 64'(bus.cmdin_in_tready), 64'd0);
    end
    bus.cmdout_out_tready = 1'b1;
    @(negedge clk);
    chk("fin1_tvalid", 64'(bus.cmdout_out_tvalid), 64'd1);
    chk("fin1_tdata", bus.cmdout_out_tdata, tid_e);
    chk("fin1_task_id_stable", bus.task_id, tid_e);
    if (offer) chk("fin1_cmdin_stall", 64'(bus.cmdin_in_tready), 64'd0);
    @(negedge clk);
    bus.cmdout_out_tready = 1'b0;
    bus.cmdin_in_tvalid   = 1'b0;
    chk("post_fin_tvalid", 64'(bus.cmdout_out_tvalid), 64'd0);
    chk("post_fin_cmdin_rdy", 64'(bus.cmdin_in_tready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    int kind;
    int n;
    int len;
    logic [63:0] h;
    bus.cmdin_in_tvalid   = 1'b0;
    bus.cmdin_in_tdata    = '0;
    bus.cmdin_in_tlast    = 1'b0;
    bus.cmdout_out_tready = 1'b0;
    bus.task_start_ready  = 1'b0;
    bus.arg_rd_idx        = '0;
    bus.task_done         = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_vals();
    rstn = 1'b1;
    #1;
    chk("rdy_after_release", 64'(bus.cmdin_in_tready), 64'd1);
    @(negedge clk);

    pkt = '{64'h0301, 64'hA5, 64'h7, 64'h10, 64'h20, 64'h30};
    run_pkt(0, 1'b0);

    pkt = '{64'h0001, 64'h1234, 64'h99};
    run_pkt(1, 1'b0);
    chk("zero_arg_err", 64'(bus.err), 64'd0);

    bus.task_done = 1'b1;
    @(negedge clk);
    bus.task_done = 1'b0;
    chk("stray_done_ignored", 64'(bus.cmdout_out_tvalid), 64'd0);

    pkt = '{64'h0002, 64'h1, 64'h2, 64'h3, 64'h4};
    run_pkt(0, 1'b0);
    mk_valid(2, 64'hBEEF, 64'h5);
    run_pkt(0, 1'b0);

    pkt = '{64'h1001, 64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
    run_pkt(0, 1'b0);
    pkt = '{64'h0201, 64'h77};
    run_pkt(0, 1'b0);
    mk_valid(1, 64'hC0DE, 64'h6);
    run_pkt(10, 1'b1);

    pkt = '{64'h0301, 64'hA5, 64'h7, 64'h10};
    send_pkt(1'b1, s);
    rstn = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rstn    = 1'b1;
    err_exp = 1'b0;
    mk_valid(3, 64'hD00D, 64'h8);
    run_pkt(0, 1'b0);

    mk_valid(4, 64'hFEED, 64'h9);
    send_pkt(1'b0, s);
    chk("pre_rst_start", 64'(bus.task_start_valid), 64'd1);
    bus.task_start_ready = 1'b1;
    @(negedge clk);
    bus.task_start_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
    bus.task_done = 1'b1;
    @(negedge clk);
    bus.task_done = 1'b0;
    chk("no_stale_finish", 64'(bus.cmdout_out_tvalid), 64'd0);
    chk("no_stale_start", 64'(bus.task_start_valid), 64'd0);
    mk_valid(0, 64'hABCD, 64'hA);
    run_pkt(2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      n    = $urandom_range(0, MAX_ARGS);
      if (kind <= 2) begin
        mk_valid(n, {$urandom, $urandom}, {$urandom, $urandom});
      end else begin
        if (kind == 3) begin
          h = {$urandom, $urandom};
          h[15:8] = 8'(n);
          len = 3 + n;
        end else if (kind == 4) begin
          h = {$urandom, $urandom};
          h[15:0] = {8'($urandom_range(MAX_ARGS + 1, 255)), 8'h01};
          len = $urandom_range(1, 6);
        end else begin
          h = {$urandom, $urandom};
          h[15:0] = {8'(n), 8'h01};
          len = $urandom_range(1, n + 5);
        end
        pkt.delete();
        pkt.push_back(h);
        for (int j = 1; j < len; j++) pkt.push_back({$urandom, $urandom});
      end
      run_pkt($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    chk("final_err", 64'(bus.err), 64'(err_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ompss_acc_cmd_endpoint.md
# ompss_acc_cmd_endpoint

Accelerator-side endpoint of the OmpSs manager command protocol. It receives execute-task packets on the cmdin stream that the manager routes to this accelerator, and parses the header, task ID, parent ID and arguments into a local register file. It then hands the task to the kernel with a valid/ready start handshake and, when the kernel completes, returns a two-word finish message on the cmdout stream. One instance sits between the manager's stream interconnect and each accelerator kernel.

## Interface
- MAX_ACCS, 16: number of accelerators; sets the cmdout tid width.
- ACC_ID, 0: this accelerator's index; driven on cmdout_out_tid; low 8 bits placed in the finish header.
- MAX_ARGS, 15: argument register-file depth.

Ports. Reset is asynchronous and active-low; there is one clock. AW = $clog2(MAX_ARGS+1).
- clk in 1: clock.
- rstn in 1: asynchronous active-low reset.
- cmdin_in_tvalid in 1: command word valid.
- cmdin_in_tready out 1: command word accepted.
- cmdin_in_tdata in 64: command word.
- cmdin_in_tlast in 1: last word of packet.
- cmdout_out_tvalid out 1: finish word valid.
- cmdout_out_tready in 1: finish word accepted.
- cmdout_out_tid out $clog2(MAX_ACCS): constant ACC_ID.
- cmdout_out_tdata out 64: finish word.
- task_start_valid out 1: task ready for kernel.
- task_start_ready in 1: kernel accepts task.
- task_id out 64: current task ID.
- task_parent_id out 64: current parent task ID.
- task_nargs out AW: argument count.
- arg_rd_idx in AW: argument read index.
- arg_rd_data out 64: argument at arg_rd_idx, combinational.
- task_done in 1: kernel-completion pulse.
- err out 1: sticky protocol error.

## Operation
- Packet format:
  - Word 0: [7:0] opcode, where 0x01 = EXEC_TASK; [15:8] nargs; [63:16] ignored.
  - Word 1: task ID.
  - Word 2: parent ID.
  - Words 3..2+nargs: arguments, stored at index 0..nargs-1.
  - cmdin_in_tlast is set on the final word only.
- Finish message:
  - Word 0: {48'h0, ACC_ID[7:0], 8'h03}.
  - Word 1: task ID.
- States:
  - S_HDR: on handshake, if opcode≠0x01, nargs>MAX_ARGS or tlast=1 → set err; go to S_HDR if tlast, else S_DRAIN. Otherwise latch nargs → S_TID.
  - S_TID: latch task ID. tlast=1 → err, S_HDR. Else → S_PID.
  - S_PID: latch parent ID.
    - nargs=0 and tlast=1 → S_EXEC.
    - nargs=0 and tlast=0 → err, S_DRAIN.
    - nargs>0 and tlast=1 → err, S_HDR.
    - Otherwise → S_ARG with argument counter=0.
  - S_ARG: write arg[cnt], cnt++.
    - Final argument (cnt=nargs-1) with tlast → S_EXEC.
    - Final argument without tlast → err, S_DRAIN.
    - Earlier tlast → err, S_HDR.
  - S_DRAIN: accept and discard words until a tlast handshake → S_HDR.
  - S_EXEC: task_start_valid=1; on task_start_ready → S_RUN.
  - S_RUN: on task_done → S_FIN0. task_done outside S_RUN is ignored.
  - S_FIN0 / S_FIN1: drive the finish words. Handshake in S_FIN0 → S_FIN1; handshake in S_FIN1 → S_HDR.
- cmdin_in_tready = 1 in S_HDR, S_TID, S_PID, S_ARG and S_DRAIN, and 0 in all other states. Commands arriving during execution are back-pressured, not buffered.
- A malformed packet never produces a task or a finish message.
- err clears only on reset.
- task_id, task_parent_id, task_nargs and the argument file hold stable from S_EXEC through S_FIN1.
- arg_rd_data is undefined when arg_rd_idx ≥ task_nargs.

## Timing
- Reset (async assert, sync release):
  - State = S_HDR.
  - cmdin_in_tready=0 while rstn=0; it goes to 1 combinationally once rstn=1.
  - cmdout_out_tvalid, task_start_valid and err = 0.
  - task_id, task_parent_id, task_nargs and cmdout_out_tdata = 0.
- Reset mid-packet or mid-task abandons all progress. No finish message is sent for the abandoned task.
- Last cmdin handshake at edge N → task_start_valid=1 in cycle N+1.
- task_done sampled at edge M in S_RUN → cmdout_out_tvalid=1 with word 0 in cycle M+1.
- After the S_FIN1 handshake, cmdin_in_tready=1 in the next cycle, so a new packet header can be accepted one cycle after the finish.
- cmdout_out_tvalid and cmdout_out_tdata hold stable until tready. No tvalid bubble between FIN0 and FIN1 when tready is held high.
- Streaming rate: one word per cycle with no bubbles in the receive states.

## Test plan
- Valid 3-arg packet (hdr 0x0301, tid 0xA5, pid 0x7, args 0x10/0x20/0x30, tlast on 0x30):
  - task_start_valid one cycle after the final word, task_id=0xA5, task_parent_id=0x7, task_nargs=3, arg_rd_data(1)=0x20.
  - After task_done: cmdout words 0x0000_0000_0000_0003 (ACC_ID=0) then 0xA5; tid=ACC_ID.
- Zero-arg packet (hdr 0x0001, tid, pid with tlast) → start with nargs=0, err=0.
- Opcode 0x02, 5-word packet → all 5 words drained, err=1, no task_start_valid or cmdout; the next valid packet executes normally.
- nargs=16 with MAX_ARGS=15 → drain to tlast, err=1. A separate packet with early tlast on the tid word → err=1, back to S_HDR with no drain.
- cmdout_out_tready held low for 10 cycles in FIN0 → tvalid and word 0 stay stable. A new packet offered meanwhile sees cmdin_in_tready=0 until the FIN1 handshake.
- rstn pulsed low during S_ARG and again during S_RUN → outputs at reset values immediately; the following packet is parsed correctly; no stale finish message.
